// File: rtl/apb_xip_cache.sv
`default_nettype none
// ============================================================================
// Module   : apb_xip_cache
// Brief    : Direct-mapped, one-word-per-line read cache on the APB path in
//            front of the SPI flash XIP controller. Window read hits return
//            with zero wait states. Misses and all non-window traffic go
//            downstream as one registered APB transfer.
// Revision : 1.0 - initial release
// ============================================================================
module apb_xip_cache #(
  parameter logic [31:0] flash_addr_start = 32'h3000_0000,
  parameter logic [31:0] flash_addr_end   = 32'h3fff_ffff,
  parameter int unsigned lines_log2       = 4
) (
  input  logic        clock,
  input  logic        reset,
  // upstream APB slave
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  // downstream APB master
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  // maintenance and statistics
  input  logic        cache_flush,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned C_LINES = 1 << lines_log2;
  localparam int unsigned C_TAG_W = 26 - lines_log2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACC  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  // The downstream request registers double as the latched upstream request.
  logic [31:0] out_paddr_q, out_paddr_d;
  logic        out_psel_q, out_psel_d;
  logic        out_penable_q, out_penable_d;
  logic [2:0]  out_pprot_q, out_pprot_d;
  logic        out_pwrite_q, out_pwrite_d;
  logic [31:0] out_pwdata_q, out_pwdata_d;
  logic [3:0]  out_pstrb_q, out_pstrb_d;

  logic        win_q, win_d;        // in-flight request is a window read
  logic        poison_q, poison_d;  // a flush hit the in-flight fill
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [C_LINES-1:0] valid_q, valid_d;

  logic [C_TAG_W-1:0] tag_mem  [C_LINES];
  logic [31:0]        data_mem [C_LINES];

  logic                  w_in_win;
  logic [lines_log2-1:0] w_in_idx;
  logic [C_TAG_W-1:0]    w_in_tag;
  logic                  w_lookup_hit;
  logic [lines_log2-1:0] w_fill_idx;
  logic [C_TAG_W-1:0]    w_fill_tag;
  logic                  w_alloc;

  assign w_in_win     = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
  assign w_in_idx     = in_paddr[lines_log2+1:2];
  assign w_in_tag     = in_paddr[27:lines_log2+2];
  assign w_lookup_hit = valid_q[w_in_idx] && (tag_mem[w_in_idx] == w_in_tag);
  assign w_fill_idx   = out_paddr_q[lines_log2+1:2];
  assign w_fill_tag   = out_paddr_q[27:lines_log2+2];

  // Next-state, upstream response and register updates for the transfer FSM.
  always_comb begin
    state_d       = state_q;
    out_paddr_d   = out_paddr_q;
    out_psel_d    = out_psel_q;
    out_penable_d = out_penable_q;
    out_pprot_d   = out_pprot_q;
    out_pwrite_d  = out_pwrite_q;
    out_pwdata_d  = out_pwdata_q;
    out_pstrb_d   = out_pstrb_q;
    win_d         = win_q;
    poison_d      = poison_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    valid_d       = valid_q;
    w_alloc       = 1'b0;
    in_pready     = 1'b0;
    in_prdata     = 32'h0;
    in_pslverr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_psel && in_penable) begin
          if (w_in_win && !in_pwrite && w_lookup_hit) begin
            in_pready = 1'b1;
            in_prdata = data_mem[w_in_idx];
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else if (w_in_win && in_pwrite) begin
            // flash is read-only through this path: reject without forwarding
            in_pready  = 1'b1;
            in_pslverr = 1'b1;
          end else begin
            state_d       = REQ;
            win_d         = w_in_win;
            poison_d      = 1'b0;
            out_psel_d    = 1'b1;
            out_penable_d = 1'b0;
            out_pprot_d   = in_pprot;
            out_pwdata_d  = in_pwdata;
            if (w_in_win) begin
              out_paddr_d  = {in_paddr[31:2], 2'b00};
              out_pwrite_d = 1'b0;
              out_pstrb_d  = 4'h0;
              miss_cnt_d   = miss_cnt_q + 32'd1;
            end else begin
              out_paddr_d  = in_paddr;
              out_pwrite_d = in_pwrite;
              out_pstrb_d  = in_pstrb;
            end
          end
        end
      end
      REQ: begin
        state_d       = ACC;
        out_penable_d = 1'b1;
        if (cache_flush) poison_d = 1'b1;
      end
      ACC: begin
        if (cache_flush) poison_d = 1'b1;
        if (out_pready) begin
          state_d       = RESP;
          rdata_d       = out_prdata;
          err_d         = out_pslverr;
          w_alloc       = win_q && !out_pslverr && !poison_q && !cache_flush;
          out_paddr_d   = 32'h0;
          out_psel_d    = 1'b0;
          out_penable_d = 1'b0;
          out_pprot_d   = 3'h0;
          out_pwrite_d  = 1'b0;
          out_pwdata_d  = 32'h0;
          out_pstrb_d   = 4'h0;
        end
      end
      RESP: begin
        in_pready  = 1'b1;
        in_prdata  = rdata_q;
        in_pslverr = err_q;
        rdata_d    = 32'h0;
        err_d      = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (w_alloc) valid_d[w_fill_idx] = 1'b1;
    // flush is applied last so it wins over a same-edge allocation
    if (cache_flush) valid_d = '0;
  end

  // Control, request and statistics registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      out_paddr_q   <= 32'h0;
      out_psel_q    <= 1'b0;
      out_penable_q <= 1'b0;
      out_pprot_q   <= 3'h0;
      out_pwrite_q  <= 1'b0;
      out_pwdata_q  <= 32'h0;
      out_pstrb_q   <= 4'h0;
      win_q         <= 1'b0;
      poison_q      <= 1'b0;
      rdata_q       <= 32'h0;
      err_q         <= 1'b0;
      hit_cnt_q     <= 32'h0;
      miss_cnt_q    <= 32'h0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      out_paddr_q   <= out_paddr_d;
      out_psel_q    <= out_psel_d;
      out_penable_q <= out_penable_d;
      out_pprot_q   <= out_pprot_d;
      out_pwrite_q  <= out_pwrite_d;
      out_pwdata_q  <= out_pwdata_d;
      out_pstrb_q   <= out_pstrb_d;
      win_q         <= win_d;
      poison_q      <= poison_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      valid_q       <= valid_d;
    end
  end

  // Tag and data arrays are unreset storage, written only on allocation.
  always_ff @(posedge clock) begin
    if (w_alloc) begin
      tag_mem[w_fill_idx]  <= w_fill_tag;
      data_mem[w_fill_idx] <= out_prdata;
    end
  end

  assign out_paddr   = out_paddr_q;
  assign out_psel    = out_psel_q;
  assign out_penable = out_penable_q;
  assign out_pprot   = out_pprot_q;
  assign out_pwrite  = out_pwrite_q;
  assign out_pwdata  = out_pwdata_q;
  assign out_pstrb   = out_pstrb_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule
`default_nettype wire
